// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard and forwarding controller for the in-order pipeline. A shift chain
// of NUM_STAGES entries records the destination of every instruction from EX
// onward. Each decode read port gets a forward select (youngest writer wins)
// and a load-use hazard flag; any hazard on a live, unflushed decode
// instruction raises stall, which holds PC and IF/ID and pushes a bubble.
//
// Handshake: there is no valid/ready pair here. id_valid qualifies the decode
// inputs. An instruction is accepted into entry 1 on an edge only when
// id_valid=1, stall=0 and flush=0; otherwise entry 1 becomes a bubble and the
// decode stage is expected to hold its inputs while stall=1.
module hazard_scoreboard #(
   parameter int  REG_AW     = 5,
   parameter int  NUM_STAGES = 3,
   parameter int  NUM_RD     = 2,
   parameter int  LOAD_LAT   = 2,
   localparam int SELW       = $clog2(NUM_STAGES + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     id_valid,
   input  logic [NUM_RD-1:0]        id_rd_en,
   input  logic [NUM_RD*REG_AW-1:0] id_rs,
   input  logic                     id_we,
   input  logic [REG_AW-1:0]        id_wd,
   input  logic                     id_is_load,
   input  logic                     flush,
   output logic                     stall,
   output logic [NUM_RD*SELW-1:0]   fwd_sel,
   output logic [15:0]              stall_cnt
);

   // Scoreboard entries; index k is the instruction currently in stage k.
   logic              r_v  [1:NUM_STAGES];
   logic              r_we [1:NUM_STAGES];
   logic [REG_AW-1:0] r_wd [1:NUM_STAGES];
   logic              r_ld [1:NUM_STAGES];
   logic [15:0]       r_stall_cnt;

   logic [NUM_STAGES:1]    w_match [NUM_RD];
   logic [NUM_RD-1:0]      w_hazard;
   logic [NUM_RD*SELW-1:0] w_fwd_sel;
   logic                   w_stall;
   logic                   w_issue;

   // Per-port, per-stage match; register 0 and disabled ports never match.
   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         w_match[p] = '0;
         for (int k = 1; k <= NUM_STAGES; k++) begin
            w_match[p][k] = r_v[k] && r_we[k] && id_rd_en[p] &&
                            (r_wd[k] == id_rs[p*REG_AW +: REG_AW]) &&
                            (id_rs[p*REG_AW +: REG_AW] != '0);
         end
      end
   end

   // Youngest-writer priority: scan oldest to youngest so the last hit wins.
   always_comb begin
      w_fwd_sel = '0;
      w_hazard  = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         for (int k = NUM_STAGES; k >= 1; k--) begin
            if (w_match[p][k]) begin
               w_fwd_sel[p*SELW +: SELW] = SELW'(k);
               w_hazard[p]               = r_ld[k] && (k < LOAD_LAT);
            end
         end
      end
   end

   // A squashed or empty decode slot never holds the PC.
   always_comb begin
      w_stall = id_valid && !flush && (|w_hazard);
      w_issue = id_valid && !w_stall && !flush;
   end

   // Shift chain: entry 1 takes the accepted decode instruction or a bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 1; k <= NUM_STAGES; k++) begin
            r_v[k]  <= 1'b0;
            r_we[k] <= 1'b0;
            r_wd[k] <= '0;
            r_ld[k] <= 1'b0;
         end
      end else begin
         for (int k = NUM_STAGES; k >= 2; k--) begin
            r_v[k]  <= r_v[k-1];
            r_we[k] <= r_we[k-1];
            r_wd[k] <= r_wd[k-1];
            r_ld[k] <= r_ld[k-1];
         end
         r_v[1]  <= w_issue;
         r_we[1] <= w_issue && id_we;
         r_wd[1] <= id_wd;
         r_ld[1] <= w_issue && id_is_load;
      end
   end

   // Saturating count of cycles spent stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall     = w_stall;
   assign fwd_sel   = w_fwd_sel;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset and parameter
// sweep sequences, and randomized traffic against an issue-history model.
module tb_hazard_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default-parameter instance
   logic        a_rst_n, a_valid, a_we, a_ld, a_flush, a_stall;
   logic [1:0]  a_rd_en;
   logic [9:0]  a_rs;
   logic [4:0]  a_wd;
   logic [3:0]  a_fwd;
   logic [15:0] a_cnt;

   // Sweep instance: 5 stages, load latency 4, 3 read ports
   logic        b_rst_n, b_valid, b_we, b_ld, b_flush, b_stall;
   logic [2:0]  b_rd_en;
   logic [14:0] b_rs;
   logic [4:0]  b_wd;
   logic [8:0]  b_fwd;
   logic [15:0] b_cnt;

   hazard_scoreboard #(.REG_AW(5), .NUM_STAGES(3), .NUM_RD(2), .LOAD_LAT(2)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .id_valid(a_valid), .id_rd_en(a_rd_en),
      .id_rs(a_rs), .id_we(a_we), .id_wd(a_wd), .id_is_load(a_ld),
      .flush(a_flush), .stall(a_stall), .fwd_sel(a_fwd), .stall_cnt(a_cnt)
   );

   hazard_scoreboard #(.REG_AW(5), .NUM_STAGES(5), .NUM_RD(3), .LOAD_LAT(4)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .id_valid(b_valid), .id_rd_en(b_rd_en),
      .id_rs(b_rs), .id_we(b_we), .id_wd(b_wd), .id_is_load(b_ld),
      .flush(b_flush), .stall(b_stall), .fwd_sel(b_fwd), .stall_cnt(b_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       valid;
      logic [1:0] en;
      logic [4:0] rs0, rs1;
      logic       we;
      logic [4:0] wd;
      logic       ld;
      logic       flush;
      logic       chk_fwd;
      logic       exp_stall;
      int         exp_f0, exp_f1, exp_cnt;
   } vec_t;

   vec_t tbl[19];

   function automatic vec_t mk(input logic v, input logic [1:0] en,
                               input int rs0, input int rs1, input logic we,
                               input int wd, input logic ld, input logic fl,
                               input logic cf, input logic st,
                               input int f0, input int f1, input int cnt);
      vec_t r;
      r.valid = v; r.en = en; r.rs0 = 5'(rs0); r.rs1 = 5'(rs1);
      r.we = we; r.wd = 5'(wd); r.ld = ld; r.flush = fl; r.chk_fwd = cf;
      r.exp_stall = st; r.exp_f0 = f0; r.exp_f1 = f1; r.exp_cnt = cnt;
      return r;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      int         issued_at;
      logic       we;
      logic [4:0] wd;
      logic       ld;
   } issue_t;

   issue_t m_hist[$];
   int     m_edges = 0;
   int     m_cnt   = 0;

   // Stage of an instruction = edges since its issue edge, plus one.
   function automatic void model_port(input logic [4:0] rs, input logic en,
                                      output int sel, output logic hz);
      int best = 0;
      logic bld = 1'b0;
      foreach (m_hist[i]) begin
         int stage = m_edges - m_hist[i].issued_at + 1;
         if (stage >= 1 && stage <= 3 && en && rs != 0 &&
             m_hist[i].we && m_hist[i].wd == rs &&
             (best == 0 || stage < best)) begin
            best = stage;
            bld  = m_hist[i].ld;
         end
      end
      sel = best;
      hz  = (best != 0) && bld && (best < 2);
   endfunction

   task automatic a_drive(input logic v, input logic [1:0] en, input logic [4:0] rs0,
                          input logic [4:0] rs1, input logic we, input logic [4:0] wd,
                          input logic ld, input logic fl);
      a_valid = v; a_rd_en = en; a_rs = {rs1, rs0};
      a_we = we; a_wd = wd; a_ld = ld; a_flush = fl;
   endtask

   initial begin
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      a_drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      b_valid = 1'b0; b_rd_en = '0; b_rs = '0; b_we = 1'b0; b_wd = '0;
      b_ld = 1'b0; b_flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      a_rst_n = 1'b1; b_rst_n = 1'b1;

      // ---- reset with a load of r5 in flight ----
      a_drive(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
      @(negedge clk);
      a_drive(1'b1, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1 check("pre_reset_stall", int'(a_stall), 1);
      @(negedge clk);
      #1 check("pre_reset_cnt", int'(a_cnt), 1);
      check("pre_reset_fwd0", int'(a_fwd[1:0]), 2);
      a_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      a_rst_n = 1'b1;
      #1 check("reset_stall", int'(a_stall), 0);
      check("reset_fwd0", int'(a_fwd[1:0]), 0);
      check("reset_fwd1", int'(a_fwd[3:2]), 0);
      check("reset_cnt", int'(a_cnt), 0);

      // ---- table: ALU forwarding, load-use, youngest wins, r0, flush ----
      //            v  en     rs0 rs1 we wd ld fl  cf st  f0 f1 cnt
      tbl[0]  = mk(1, 2'b11, 1, 2, 1, 3, 0, 0, 1, 0, 0, 0, 0);
      tbl[1]  = mk(1, 2'b01, 3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      tbl[2]  = mk(1, 2'b11, 3, 3, 0, 0, 0, 0, 1, 0, 2, 2, 0);
      tbl[3]  = mk(1, 2'b10, 3, 3, 0, 0, 0, 0, 1, 0, 0, 3, 0);
      tbl[4]  = mk(1, 2'b01, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[5]  = mk(1, 2'b00, 0, 0, 1, 4, 1, 0, 1, 0, 0, 0, 0);
      tbl[6]  = mk(1, 2'b10, 0, 4, 1, 6, 0, 0, 1, 1, 0, 1, 0);
      tbl[7]  = mk(1, 2'b10, 0, 4, 1, 6, 0, 0, 1, 0, 0, 2, 1);
      tbl[8]  = mk(1, 2'b00, 0, 0, 1, 7, 0, 0, 1, 0, 0, 0, 1);
      tbl[9]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      tbl[10] = mk(1, 2'b00, 0, 0, 1, 7, 0, 0, 1, 0, 0, 0, 1);
      tbl[11] = mk(1, 2'b01, 7, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1);
      tbl[12] = mk(1, 2'b11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      tbl[13] = mk(1, 2'b00, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0, 1);
      tbl[14] = mk(1, 2'b01, 2, 0, 1, 9, 0, 1, 1, 0, 1, 0, 1);
      tbl[15] = mk(1, 2'b11, 2, 9, 0, 0, 0, 0, 1, 0, 2, 0, 1);
      tbl[16] = mk(1, 2'b00, 0, 0, 1, 5, 1, 0, 1, 0, 0, 0, 1);
      tbl[17] = mk(0, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[18] = mk(1, 2'b01, 5, 0, 0, 0, 0, 0, 1, 0, 2, 0, 1);

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         a_drive(tbl[i].valid, tbl[i].en, tbl[i].rs0, tbl[i].rs1, tbl[i].we,
                 tbl[i].wd, tbl[i].ld, tbl[i].flush);
         #1;
         check($sformatf("vec%0d_stall", i), int'(a_stall), int'(tbl[i].exp_stall));
         check($sformatf("vec%0d_cnt", i), int'(a_cnt), tbl[i].exp_cnt);
         if (tbl[i].chk_fwd) begin
            check($sformatf("vec%0d_fwd0", i), int'(a_fwd[1:0]), tbl[i].exp_f0);
            check($sformatf("vec%0d_fwd1", i), int'(a_fwd[3:2]), tbl[i].exp_f1);
         end
      end

      // ---- randomized traffic against the issue-history model ----
      @(negedge clk);
      a_rst_n = 1'b0;
      @(posedge clk);
      m_hist.delete();
      m_cnt = 0;
      for (int c = 0; c < 600; c++) begin
         int   e0, e1;
         logic h0, h1, e_stall;
         @(negedge clk);
         a_rst_n = ($urandom_range(0, 63) != 0);
         a_drive($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 7, 5'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
         #1;
         model_port(a_rs[4:0], a_rd_en[0], e0, h0);
         model_port(a_rs[9:5], a_rd_en[1], e1, h1);
         e_stall = a_valid && !a_flush && (h0 || h1);
         check("rnd_stall", int'(a_stall), int'(e_stall));
         check("rnd_cnt", int'(a_cnt), m_cnt);
         if (a_valid) begin
            check("rnd_fwd0", int'(a_fwd[1:0]), e0);
            check("rnd_fwd1", int'(a_fwd[3:2]), e1);
         end
         @(posedge clk);
         m_edges++;
         if (!a_rst_n) begin
            m_hist.delete();
            m_cnt = 0;
         end else begin
            issue_t it;
            if (e_stall && m_cnt != 16'hFFFF) m_cnt++;
            if (a_valid && !e_stall && !a_flush) begin
               it.issued_at = m_edges; it.we = a_we; it.wd = a_wd; it.ld = a_ld;
               m_hist.push_back(it);
            end
            while (m_hist.size() > 0 && m_edges - m_hist[0].issued_at + 1 > 3)
               void'(m_hist.pop_front());
         end
      end
      @(negedge clk);
      a_rst_n = 1'b1;
      a_valid = 1'b0;

      // ---- sweep instance: load latency 4 gives a 3-cycle load-use stall ----
      @(negedge clk);
      b_valid = 1'b1; b_rd_en = 3'b000; b_rs = '0;
      b_we = 1'b1; b_wd = 5'd11; b_ld = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         b_rd_en = 3'b100; b_rs = {5'd11, 5'd0, 5'd0};
         b_we = 1'b0; b_wd = 5'd0; b_ld = 1'b0;
         #1 check($sformatf("sweep_stall_k%0d", k), int'(b_stall), 1);
         check($sformatf("sweep_fwd2_k%0d", k), int'(b_fwd[8:6]), k);
      end
      @(negedge clk);
      #1 check("sweep_release_stall", int'(b_stall), 0);
      check("sweep_release_fwd2", int'(b_fwd[8:6]), 4);
      check("sweep_cnt", int'(b_cnt), 3);

      // ---- counter saturation while stalled ----
      @(negedge clk);
      b_rd_en = 3'b000; b_rs = '0; b_we = 1'b1; b_wd = 5'd12; b_ld = 1'b1;
      @(negedge clk);
      b_rd_en = 3'b100; b_rs = {5'd12, 5'd0, 5'd0}; b_we = 1'b0; b_wd = 5'd0; b_ld = 1'b0;
      #1 check("sat_stall0", int'(b_stall), 1);
      force dut_b.r_stall_cnt = 16'hFFFE;
      #1 release dut_b.r_stall_cnt;
      #1 check("sat_preload", int'(b_cnt), 16'hFFFE);
      @(negedge clk);
      #1 check("sat_stall1", int'(b_stall), 1);
      check("sat_reach", int'(b_cnt), 16'hFFFF);
      @(negedge clk);
      #1 check("sat_stall2", int'(b_stall), 1);
      check("sat_hold", int'(b_cnt), 16'hFFFF);
      @(negedge clk);
      b_valid = 1'b0;
      #1 check("sat_hold_idle", int'(b_cnt), 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order MIPS pipeline. It tracks every in-flight destination register from the EX stage to the WB stage in a shift-register scoreboard. From that state it produces, per decode read port, a forwarding select and a load-use stall. It also produces a saturating stall counter. It sits beside the ID/EX pipeline register and replaces the fixed two-port, three-writer hazard/forward logic with a generalised stage count, read-port count and load latency.

## Interface
- REG_AW, 5, register-address width
- NUM_STAGES, 3, tracked stages after decode (1 = EX, 2 = MEM, 3 = WB)
- NUM_RD, 2, decode read ports
- LOAD_LAT, 2, first stage index at which a load's data is forwardable
- SELW, clog2(NUM_STAGES+1), derived; width of one forward select
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  decode holds a real instruction
- id_rd_en  in  NUM_RD  per-port source-read enable
- id_rs  in  NUM_RD*REG_AW  source register numbers; port p is bits [p*REG_AW +: REG_AW]
- id_we  in  1  decode instruction writes a register
- id_wd  in  REG_AW  decode destination register
- id_is_load  in  1  decode instruction is a load
- flush  in  1  branch/jump taken; decode instruction is squashed
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- fwd_sel  out  NUM_RD*SELW  per port: 0 = register file, k = forward from stage k
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- State: NUM_STAGES entries {v, we, wd, ld}; entry k describes the instruction currently in stage k.
- Each rising edge with rst_n=1:
  - entry[k+1] <= entry[k] for k = 1..NUM_STAGES-1; entry NUM_STAGES is retired.
  - entry[1] <= {1, id_we, id_wd, id_is_load} if id_valid & !stall & !flush; otherwise a bubble (v=0).
- Match for port p at stage k: v & we & (wd == rs_p) & (rs_p != 0) & id_rd_en[p].
- fwd_sel[p] = smallest matching k (youngest writer wins); 0 if there is no match.
- Port hazard: the youngest match has ld=1 and k < LOAD_LAT.
- stall = id_valid & !flush & OR(port hazards).
- fwd_sel and stall are combinational from the scoreboard state and the decode inputs; there is no state machine beyond the shift chain.
- stall_cnt increments on each edge where stall=1 and saturates at 16'hFFFF.
- Register 0 never matches. A writer with wd=0 is tracked but is inert.
- While stalled, the held decode inputs are re-evaluated every cycle. The stall clears once the load reaches stage LOAD_LAT, and fwd_sel then points at that stage.
- flush together with a hazard: stall=0 and a bubble is inserted, because the squashed instruction must not hold the PC.
- id_valid=0: stall=0; fwd_sel is still driven but is don't-care.
- Non-load writers are forwardable from stage 1 onward.

## Timing
- Reset: when rst_n=0 at an edge, all entries are cleared (v=0) and stall_cnt is set to 0. Immediately after reset, stall=0 and fwd_sel=0 for any input.
- Reset mid-operation discards all in-flight entries at that edge. No forwarding from pre-reset instructions occurs afterwards.
- Scoreboard update latency is 1 cycle: an instruction issued at edge n is visible as entry[1] after edge n.
- Default parameters give a 1-cycle load-use stall:
  - load in EX (k=1 < 2): stall=1.
  - after the next edge the load is in MEM (k=2): stall=0 and fwd_sel=2.
- With LOAD_LAT=L, a dependent instruction directly behind a load stalls L-1 cycles.
- A writer is visible for forwarding for exactly NUM_STAGES cycles after issue.

## Test plan
- Reset: drive rst_n=0 for 2 edges with id_rs=5 and a prior writer of r5 in flight -> stall=0, fwd_sel=0, stall_cnt=0 after the reset edge.
- ALU back-to-back: issue add r3 (we=1, wd=3), then the next instruction reads rs0=3 -> fwd_sel port0=1 and stall=0. After one more edge, a reader of r3 sees fwd_sel=2; after another edge, 3; then 0.
- Load-use: issue lw r4 (ld=1), then read rs1=4 -> stall=1 for exactly 1 cycle and stall_cnt=1. Next cycle fwd_sel port1=2, stall=0, and entry[1] is a bubble.
- Youngest wins: r7 written in stages 3 and 1, and a reader of r7 -> fwd_sel=1. A read of r0 with a writer of r0 in flight -> fwd_sel=0, stall=0.
- Flush vs hazard: load of r2 in EX, decode reads r2 with flush=1 -> stall=0; after the edge entry[1].v=0 and stall_cnt is unchanged.
- Parameter sweep NUM_STAGES=5, LOAD_LAT=4, NUM_RD=3: load then dependent on port2 -> exactly 3 stall cycles, then fwd_sel port2=4. Force stall_cnt to 16'hFFFF -> it stays at 16'hFFFF while stall=1.
